// File: rtl/bcd_nibble_capture.sv
// Serial MSB-first nibble capture with BCD range check, inter-bit timeout,
// abort-on-restart and a ready/valid result port with a saturating error count.
module bcd_nibble_capture #(
    parameter int MAX_VALUE = 9,
    parameter int TIMEOUT   = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [3:0] out_data,
    output logic [1:0] out_code,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [1:0] CODE_OK    = 2'b00;
    localparam logic [1:0] CODE_RANGE = 2'b01;
    localparam logic [1:0] CODE_TMO   = 2'b10;
    localparam logic [1:0] CODE_ABORT = 2'b11;

    // Idle counter compares against TIMEOUT-1 so the HOLD transition lands on
    // the TIMEOUT-th consecutive idle cycle.
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [3:0] shreg;
    logic [2:0] bit_cnt;
    logic [7:0] idle_cnt;
    logic [3:0] next_nib;
    logic       nib_oor;

    assign next_nib = {shreg[2:0], bit_in};
    assign nib_oor  = (32'(next_nib) > MAX_VALUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= 4'h0;
            bit_cnt   <= 3'd0;
            idle_cnt  <= 8'd0;
            out_data  <= 4'h0;
            out_code  <= CODE_OK;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            err_count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SHIFT;
                        busy     <= 1'b1;
                        shreg    <= 4'h0;
                        bit_cnt  <= 3'd0;
                        idle_cnt <= 8'd0;
                    end
                end

                SHIFT: begin
                    if (start) begin
                        // Restart mid-frame aborts; the coincident bit is dropped.
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_data  <= 4'h0;
                        out_code  <= CODE_ABORT;
                        out_err   <= 1'b1;
                    end else if (bit_valid) begin
                        shreg    <= next_nib;
                        bit_cnt  <= bit_cnt + 3'd1;
                        idle_cnt <= 8'd0;
                        if (bit_cnt == 3'd3) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_data  <= next_nib;
                            out_code  <= nib_oor ? CODE_RANGE : CODE_OK;
                            out_err   <= nib_oor;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_data  <= 4'h0;
                        out_code  <= CODE_TMO;
                        out_err   <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                end

                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        if (out_err && (err_count != 8'hFF))
                            err_count <= err_count + 8'd1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_nibble_capture.sv
// Directed bench for bcd_nibble_capture: inputs driven and outputs sampled on
// the falling edge, each falling edge observing the result of one rising edge.
module tb_bcd_nibble_capture;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       bit_in;
    logic       bit_valid;
    logic [3:0] out_data;
    logic [1:0] out_code;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    bcd_nibble_capture #(.MAX_VALUE(9), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .out_data  (out_data),
        .out_code  (out_code),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs for one rising edge, return at the following falling edge.
    task automatic step(input logic s, input logic b, input logic bv);
        start     = s;
        bit_in    = b;
        bit_valid = bv;
        @(negedge clk);
        start     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0d exp 0", out_valid); end
        checks++;
        if (out_data !== 4'h0) begin errors++; $display("FAIL rst_data got %0d exp 0", out_data); end
        checks++;
        if (out_code !== 2'b00) begin errors++; $display("FAIL rst_code got %0d exp 0", out_code); end
        checks++;
        if (out_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_err_busy got %0d/%0d exp 0/0", out_err, busy); end
        checks++;
        if (err_count !== 8'd0) begin errors++; $display("FAIL rst_errcnt got %0d exp 0", err_count); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Bits 0,1,1,1 -> 7, ok; result one cycle after the 4th bit.
    task automatic test_ok_frame;
        out_ready = 1'b1;
        step(1, 0, 0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ok_busy got %0d exp 1", busy); end
        step(0, 0, 1);
        step(0, 1, 1);
        step(0, 1, 1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ok_early_valid got %0d exp 0", out_valid); end
        step(0, 1, 1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'd7 || out_code !== 2'b00 || out_err !== 1'b0)
        begin errors++; $display("FAIL ok_result got v%0d d%0d c%0d e%0d exp v1 d7 c0 e0", out_valid, out_data, out_code, out_err); end
        step(0, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 4'd7 || err_count !== 8'd0)
        begin errors++; $display("FAIL ok_transfer got v%0d b%0d d%0d n%0d exp v0 b0 d7 n0", out_valid, busy, out_data, err_count); end
        out_ready = 1'b0;
    endtask

    // Bits 1,1,0,0 -> 12 is above the BCD limit.
    task automatic test_range;
        step(1, 0, 0);
        step(0, 1, 1);
        step(0, 1, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'd12 || out_code !== 2'b01 || out_err !== 1'b1)
        begin errors++; $display("FAIL range_result got v%0d d%0d c%0d e%0d exp v1 d12 c1 e1", out_valid, out_data, out_code, out_err); end
        out_ready = 1'b1;
        step(0, 0, 0);
        out_ready = 1'b0;
        checks++;
        if (err_count !== 8'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL range_errcnt got n%0d v%0d exp n1 v0", err_count, out_valid); end
    endtask

    // Boundary values: 9 is in range, 10 is not.
    task automatic test_boundary;
        out_ready = 1'b1;
        step(1, 0, 0);
        step(0, 1, 1); step(0, 0, 1); step(0, 0, 1); step(0, 1, 1);
        checks++;
        if (out_data !== 4'd9 || out_code !== 2'b00) begin errors++; $display("FAIL bnd_nine got d%0d c%0d exp d9 c0", out_data, out_code); end
        step(0, 0, 0);
        step(1, 0, 0);
        step(0, 1, 1); step(0, 0, 1); step(0, 1, 1); step(0, 0, 1);
        checks++;
        if (out_data !== 4'd10 || out_code !== 2'b01 || out_err !== 1'b1) begin errors++; $display("FAIL bnd_ten got d%0d c%0d e%0d exp d10 c1 e1", out_data, out_code, out_err); end
        step(0, 0, 0);
        checks++;
        if (err_count !== 8'd2) begin errors++; $display("FAIL bnd_errcnt got %0d exp 2", err_count); end
        out_ready = 1'b0;
    endtask

    // 15th consecutive idle cycle times out; 14 idle cycles do not.
    task automatic test_timeout;
        step(1, 0, 0);
        step(0, 1, 1);
        step(0, 0, 1);
        for (int i = 0; i < 14; i++) step(0, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_14 got v%0d b%0d exp v0 b1", out_valid, busy); end
        step(0, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || out_code !== 2'b10 || out_data !== 4'h0 || out_err !== 1'b1)
        begin errors++; $display("FAIL tmo_result got v%0d d%0d c%0d e%0d exp v1 d0 c2 e1", out_valid, out_data, out_code, out_err); end
        out_ready = 1'b1;
        step(0, 0, 0);
        out_ready = 1'b0;
        checks++;
        if (err_count !== 8'd3) begin errors++; $display("FAIL tmo_errcnt got %0d exp 3", err_count); end
        // 14 idle cycles between bits keep the frame alive.
        step(1, 0, 0);
        step(0, 0, 1);
        for (int i = 0; i < 14; i++) step(0, 0, 0);
        step(0, 1, 1);
        for (int i = 0; i < 14; i++) step(0, 0, 0);
        step(0, 0, 1);
        step(0, 1, 1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'd5 || out_code !== 2'b00)
        begin errors++; $display("FAIL tmo_resume got v%0d d%0d c%0d exp v1 d5 c0", out_valid, out_data, out_code); end
        out_ready = 1'b1;
        step(0, 0, 0);
        out_ready = 1'b0;
    endtask

    // Restart mid-frame aborts; HOLD ignores start/bit_valid while not ready.
    task automatic test_abort;
        step(1, 0, 0);
        step(0, 1, 1);
        step(1, 1, 1);
        checks++;
        if (out_valid !== 1'b1 || out_code !== 2'b11 || out_data !== 4'h0 || out_err !== 1'b1)
        begin errors++; $display("FAIL abort_result got v%0d d%0d c%0d e%0d exp v1 d0 c3 e1", out_valid, out_data, out_code, out_err); end
        for (int i = 0; i < 5; i++) begin
            step(i[0], 1, 1);
            checks++;
            if (out_valid !== 1'b1 || out_code !== 2'b11 || out_data !== 4'h0 || busy !== 1'b1)
            begin errors++; $display("FAIL abort_hold%0d got v%0d d%0d c%0d b%0d exp v1 d0 c3 b1", i, out_valid, out_data, out_code, busy); end
        end
        out_ready = 1'b1;
        step(1, 0, 0);
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || err_count !== 8'd4 || out_code !== 2'b11)
        begin errors++; $display("FAIL abort_transfer got b%0d v%0d n%0d c%0d exp b0 v0 n4 c3", busy, out_valid, err_count, out_code); end
    endtask

    // A bit coincident with start in IDLE is not captured; start right after transfer is accepted.
    task automatic test_back_to_back;
        out_ready = 1'b1;
        step(1, 1, 1);
        step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_start_bit got v%0d exp 0", out_valid); end
        step(0, 0, 1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'd0 || out_code !== 2'b00) begin errors++; $display("FAIL b2b_first got v%0d d%0d c%0d exp v1 d0 c0", out_valid, out_data, out_code); end
        step(0, 0, 0);
        step(1, 0, 0);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_restart got b%0d v%0d exp b1 v0", busy, out_valid); end
        step(0, 0, 1); step(0, 0, 1); step(0, 1, 1); step(0, 1, 1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'd3) begin errors++; $display("FAIL b2b_second got v%0d d%0d exp v1 d3", out_valid, out_data); end
        step(0, 0, 0);
        out_ready = 1'b0;
    endtask

    // Asynchronous reset mid-frame, then error-count saturation.
    task automatic test_reset_mid_and_saturate;
        step(1, 0, 0);
        step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || err_count !== 8'd0 || out_data !== 4'h0 || out_code !== 2'b00)
        begin errors++; $display("FAIL rstmid got b%0d v%0d n%0d d%0d c%0d exp all 0", busy, out_valid, err_count, out_data, out_code); end
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 1);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_release got b%0d v%0d exp 0 0", busy, out_valid); end
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            step(1, 0, 0);
            step(1, 0, 0);
            step(0, 0, 0);
            if (i == 253) begin
                checks++;
                if (err_count !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d exp 254", err_count); end
            end
            if (i == 254) begin
                checks++;
                if (err_count !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d exp 255", err_count); end
            end
        end
        checks++;
        if (err_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", err_count); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_ok_frame;
        test_range;
        test_boundary;
        test_timeout;
        test_abort;
        test_back_to_back;
        test_reset_mid_and_saturate;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_nibble_capture.md
BCD_NIBBLE_CAPTURE -- requirements
Module: bcd_nibble_capture

Interface
REQ-001 SHALL have parameter MAX_VALUE, default 9: largest in-range nibble value (BCD limit).
REQ-002 SHALL have parameter TIMEOUT, default 15: consecutive idle cycles allowed between bits of a frame, range 1..255.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse opening a new frame.
REQ-006 SHALL have port bit_in  input  1  serial data bit, MSB first.
REQ-007 SHALL have port bit_valid  input  1  bit_in is valid this cycle.
REQ-008 SHALL have port out_data  output  4  captured nibble.
REQ-009 SHALL have port out_code  output  2  status: 00 ok, 01 out of range, 10 timeout, 11 aborted by start.
REQ-010 SHALL have port out_err  output  1  high when out_code != 00.
REQ-011 SHALL have port out_valid  output  1  out_data/out_code/out_err are valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port busy  output  1  high in SHIFT or HOLD.
REQ-014 SHALL have port err_count  output  8  saturating count of error results delivered.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, HOLD; all outputs registered.
REQ-016 In IDLE: start -> SHIFT next cycle, shift register and bit counter cleared; bit_valid ignored, including when it coincides with start.
REQ-017 In SHIFT: each bit_valid cycle shifts bit_in into the LSB (data = {data[2:0], bit_in}), increments bit counter, clears idle counter.
REQ-018 On acceptance of the 4th bit: next cycle state HOLD, out_valid=1, out_data = assembled nibble, out_code = 01 if nibble > MAX_VALUE (unsigned 4-bit compare) else 00; latency 1 cycle after 4th bit.
REQ-019 In SHIFT, each cycle without bit_valid increments idle counter; on the TIMEOUT-th consecutive idle cycle -> HOLD with out_code=10, out_data=4'h0.
REQ-020 In SHIFT, start (with or without bit_valid) -> HOLD with out_code=11, out_data=4'h0; the bit is discarded, no new frame opened.
REQ-021 In HOLD: out_valid, out_data, out_code, out_err held stable; start and bit_valid ignored.
REQ-022 Transfer occurs on a cycle with out_valid && out_ready; next cycle state IDLE, out_valid=0; out_data/out_code retain last values.
REQ-023 out_valid SHALL never be asserted in IDLE or SHIFT; out_ready outside HOLD has no effect.
REQ-024 err_count SHALL increment by 1 on each transfer with out_err=1, saturating at 255 (no wrap).
REQ-025 Minimum frame-to-frame period: start accepted the cycle after transfer (IDLE reached).

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, out_valid=0, out_data=0, out_code=00, out_err=0, busy=0, err_count=0, counters and shift register 0.
REQ-027 Reset asserted mid-frame or in HOLD SHALL discard the frame without producing a result; release is synchronous-clean (first edge after release sees IDLE).

Verification
REQ-028 start, bits 0,1,1,1 on consecutive cycles, out_ready=1 -> out_valid one cycle after 4th bit, out_data=7, out_code=00, err_count=0.
REQ-029 start, bits 1,1,0,0 -> out_data=12, out_code=01, out_err=1; after transfer err_count=1.
REQ-030 start, 2 bits, then 15 idle cycles -> HOLD on 15th idle cycle, out_code=10, out_data=0; 14 idle cycles then bit resumes frame normally.
REQ-031 start, 1 bit, start+bit_valid same cycle -> out_code=11, frame not restarted; out_ready held 0 for 5 cycles -> outputs stable, start ignored.
REQ-032 rst_n low during SHIFT after 3 bits -> all outputs reset at once; 256 error transfers -> err_count holds 255.
